// File: rtl/reg_scoreboard.sv
// reg_scoreboard: read-side hazard tracker for the 32-entry integer register
// file. Keeps a small outstanding-write counter per register (issue marks,
// writeback clears) and withholds issue_ready while a source operand is
// still pending or while the destination counter is saturated.
//
// Ports
//   clk, rst        clock (posedge) and synchronous active-high reset
//   issue_*         decode-side instruction description; issue_ready is
//                   combinational and independent of issue_valid
//   wb_valid/wb_rd_addr  one retiring write per cycle
//   flush           discard every in-flight write
//   busy_mask       registered per-register pending bits
//   pending_any     registered OR of busy_mask
//   wb_underflow    sticky: writeback hit a register with no pending write
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic                issue_rs1_used,
  input  logic [ADDR_W-1:0]   issue_rs1_addr,
  input  logic                issue_rs2_used,
  input  logic [ADDR_W-1:0]   issue_rs2_addr,
  input  logic                issue_rd_wen,
  input  logic [ADDR_W-1:0]   issue_rd_addr,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                pending_any,
  output logic                wb_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt     [NUM_REGS];
  logic [CNT_W-1:0]    cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] inc_v;
  logic [NUM_REGS-1:0] dec_v;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                rs1_hold;
  logic                rs2_hold;
  logic                rd_full;
  logic                fire;
  logic                uf_hit;

  // x0 is never pending, so a zero address can never cause a stall.
  function automatic logic is_busy(input logic [ADDR_W-1:0] a,
                                   input logic [CNT_W-1:0]  c);
    return (a != '0) && (c != '0);
  endfunction

  // Saturation guard: a full counter stalls the issue instead of wrapping.
  function automatic logic cnt_full(input logic [CNT_W-1:0] c);
    return c == CNT_MAX;
  endfunction

  always_comb begin
    rs1_hold    = issue_rs1_used && is_busy(issue_rs1_addr, cnt[issue_rs1_addr]);
    rs2_hold    = issue_rs2_used && is_busy(issue_rs2_addr, cnt[issue_rs2_addr]);
    rd_full     = issue_rd_wen && (issue_rd_addr != '0) && cnt_full(cnt[issue_rd_addr]);
    issue_ready = !flush && !rs1_hold && !rs2_hold && !rd_full;
    fire        = issue_valid && issue_ready;
    // Flush discards the writeback of its cycle, including the error flag.
    uf_hit      = wb_valid && !flush && (wb_rd_addr != '0) && (cnt[wb_rd_addr] == '0);
  end

  always_comb begin
    inc_v    = '0;
    dec_v    = '0;
    busy_nxt = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = cnt[r];
      inc_v[r]   = fire && issue_rd_wen && (issue_rd_addr == ADDR_W'(r));
      dec_v[r]   = wb_valid && !flush && (wb_rd_addr == ADDR_W'(r)) && (cnt[r] != '0);
      if (r == 0 || flush) begin
        cnt_nxt[r] = '0;
      end else if (inc_v[r] && !dec_v[r]) begin
        cnt_nxt[r] = cnt[r] + CNT_W'(1);
      end else if (dec_v[r] && !inc_v[r]) begin
        cnt_nxt[r] = cnt[r] - CNT_W'(1);
      end
      busy_nxt[r] = (cnt_nxt[r] != '0);
    end
  end

  // State boundary: counters and their registered summaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      busy_mask    <= '0;
      pending_any  <= 1'b0;
      wb_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
      busy_mask   <= busy_nxt;
      pending_any <= |busy_nxt;
      if (uf_hit) wb_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized plus directed bench for reg_scoreboard, checked against a
// behavioural model that tracks outstanding writes per register as integers.
module tb_reg_scoreboard;

  localparam int NR  = 32;
  localparam int MAX = 3;

  logic        clk = 1'b0;
  logic        rst, issue_valid, issue_ready;
  logic        issue_rs1_used, issue_rs2_used, issue_rd_wen;
  logic [4:0]  issue_rs1_addr, issue_rs2_addr, issue_rd_addr, wb_rd_addr;
  logic        wb_valid, flush;
  logic [31:0] busy_mask;
  logic        pending_any, wb_underflow;

  int n_tot = 0;
  int n_bad = 0;
  int m_cnt [NR];
  bit m_uf;
  logic last_ready;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1_used(issue_rs1_used), .issue_rs1_addr(issue_rs1_addr),
    .issue_rs2_used(issue_rs2_used), .issue_rs2_addr(issue_rs2_addr),
    .issue_rd_wen(issue_rd_wen), .issue_rd_addr(issue_rd_addr),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .flush(flush),
    .busy_mask(busy_mask), .pending_any(pending_any), .wb_underflow(wb_underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tot++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    for (int r = 1; r < NR; r++) m[r] = (m_cnt[r] != 0);
    return m;
  endfunction

  // One clock: drive inputs, check issue_ready against the model, clock,
  // advance the model, check the registered outputs.
  task automatic cyc(input logic r, input logic fl, input logic iv,
                     input logic u1, input logic [4:0] a1,
                     input logic u2, input logic [4:0] a2,
                     input logic wen, input logic [4:0] rd,
                     input logic wbv, input logic [4:0] wb);
    bit exp_ready, fire;
    int nxt [NR];
    rst = r; flush = fl; issue_valid = iv;
    issue_rs1_used = u1; issue_rs1_addr = a1;
    issue_rs2_used = u2; issue_rs2_addr = a2;
    issue_rd_wen = wen; issue_rd_addr = rd;
    wb_valid = wbv; wb_rd_addr = wb;
    #1;
    exp_ready = !fl
      && !(u1 && a1 != 0 && m_cnt[a1] != 0)
      && !(u2 && a2 != 0 && m_cnt[a2] != 0)
      && !(wen && rd != 0 && m_cnt[rd] == MAX);
    last_ready = issue_ready;
    chk("issue_ready", issue_ready, exp_ready);
    fire = iv && exp_ready;
    for (int i = 0; i < NR; i++) nxt[i] = m_cnt[i];
    if (r) begin
      for (int i = 0; i < NR; i++) nxt[i] = 0;
      m_uf = 0;
    end else if (fl) begin
      for (int i = 0; i < NR; i++) nxt[i] = 0;
    end else begin
      if (fire && wen && rd != 0) nxt[rd] = nxt[rd] + 1;
      if (wbv && wb != 0) begin
        if (m_cnt[wb] == 0) m_uf = 1;
        else nxt[wb] = nxt[wb] - 1;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) m_cnt[i] = nxt[i];
    chk("busy_mask", busy_mask, model_mask());
    chk("pending_any", pending_any, model_mask() != 0);
    chk("wb_underflow", wb_underflow, m_uf);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    cyc(0, 0, 1, 0, 0, 0, 0, 1, rd, 0, 0);
  endtask

  task automatic wb_only(input logic [4:0] wb);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, wb);
  endtask

  initial begin
    rst = 1; flush = 0; issue_valid = 0;
    issue_rs1_used = 0; issue_rs1_addr = 0; issue_rs2_used = 0; issue_rs2_addr = 0;
    issue_rd_wen = 0; issue_rd_addr = 0; wb_valid = 0; wb_rd_addr = 0;
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    m_uf = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", busy_mask, 32'h0);
    chk("rst_pend", pending_any, 1'b0);
    chk("rst_uf", wb_underflow, 1'b0);
    chk("rst_ready", issue_ready, 1'b1);

    // Basic RAW dependency on x5.
    issue_wr(5);
    chk("t1_busy", busy_mask, 32'h20);
    cyc(0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    chk("t1_stall", last_ready, 1'b0);
    wb_only(5);
    chk("t1_clear", busy_mask, 32'h0);
    cyc(0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    chk("t1_go", last_ready, 1'b1);

    // x0 never pending.
    issue_wr(0);
    cyc(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    chk("t2_ready", last_ready, 1'b1);
    wb_only(0);
    chk("t2_busy", busy_mask, 32'h0);
    chk("t2_uf", wb_underflow, 1'b0);

    // Saturation on x7.
    repeat (3) issue_wr(7);
    issue_wr(7);
    chk("t3_full", last_ready, 1'b0);
    wb_only(7);
    issue_wr(7);
    chk("t3_after_wb", last_ready, 1'b1);
    repeat (3) wb_only(7);
    chk("t3_drain", busy_mask, 32'h0);

    // Same-cycle inc and dec on x9.
    issue_wr(9);
    cyc(0, 0, 1, 0, 0, 0, 0, 1, 9, 1, 9);
    chk("t4_busy9", busy_mask[9], 1'b1);
    wb_only(9);
    chk("t4_clear9", busy_mask[9], 1'b0);

    // Sticky underflow.
    wb_only(12);
    chk("t5_uf", wb_underflow, 1'b1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_uf_flush", wb_underflow, 1'b1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_uf_rst", wb_underflow, 1'b0);

    // Flush with concurrent issue and wb, then reset mid-stream.
    issue_wr(3);
    issue_wr(4);
    chk("t6_busy", busy_mask, 32'h18);
    cyc(0, 1, 1, 0, 0, 0, 0, 1, 8, 1, 3);
    chk("t6_flush_ready", last_ready, 1'b0);
    chk("t6_flush_mask", busy_mask, 32'h0);
    issue_wr(10);
    issue_wr(11);
    cyc(1, 0, 1, 0, 0, 0, 0, 1, 13, 1, 10);
    chk("t6_rst_mask", busy_mask, 32'h0);
    chk("t6_rst_pend", pending_any, 1'b0);

    // Random traffic over a narrow address range to provoke hazards.
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 39) == 0),
          $urandom_range(0, 1),
          $urandom_range(0, 1), 5'($urandom_range(0, 7)),
          $urandom_range(0, 1), 5'($urandom_range(0, 7)),
          ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
          ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
